if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the PC, drives the instruction-memory address, and owns the IF/ID pipeline register. That register's instruction output is the `instruction_ir` operand seen by the load-use hazard checker, and this block obeys the checker's `pc_write`/`if_id_write` stall controls. It also applies branch/jump redirects with IF/ID flush, tolerates multi-cycle instruction memory via a ready handshake, and flags a stuck memory with a timeout.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID as a bubble
TIMEOUT, 16, consecutive not-ready cycles before imem_timeout sets (>=2)
CNT_W, 5, width of the wait counter (must hold TIMEOUT)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
pc_write  input  1  1 = PC may advance; 0 = hold (load-use stall)
if_id_write  input  1  1 = IF/ID may load; 0 = hold contents
branch_taken  input  1  taken branch resolved in ID
branch_target  input  32  branch destination
jump  input  1  jump resolved in ID
jump_target  input  32  jump destination
imem_addr  output  32  instruction-memory address, equals pc (combinational)
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  1 = imem_rdata valid this cycle
pc  output  32  current PC register
if_id_instr  output  32  IF/ID instruction (to decode and hazard checker)
if_id_pc4  output  32  IF/ID PC+4 of that instruction
if_id_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble
fetch_wait  output  1  registered: 1 while FSM in WAIT
imem_timeout  output  1  sticky error flag

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0.
  - FSM=FETCH, wait_cnt=0, fetch_wait=0, imem_timeout=0.
  - Reset overrides every other input, including mid-WAIT.
- imem_addr = pc, combinational. PC+4 is 32-bit wrap-around arithmetic (0xFFFF_FFFC+4 = 0).
- redirect = branch_taken | jump. If both are asserted, branch_target wins.
- PC next-state, per edge, in priority order:
  1. redirect: pc <= target.
  2. pc_write=0: hold.
  3. imem_ready=0: hold.
  4. Otherwise: pc <= pc+4.
- IF/ID next-state, per edge, in priority order:
  1. redirect: bubble. This overrides if_id_write=0, because the wrong-path fetch is discarded.
  2. if_id_write=0: hold all three fields.
  3. imem_ready=0: bubble.
  4. pc_write=0: bubble, which prevents duplicate issue.
  5. Otherwise: load instr=imem_rdata, pc4=pc+4, valid=1.
- A bubble is instr=NOP_INSTR, pc4=0, valid=0.
- Latency: an instruction is visible on if_id_instr one cycle after the edge where its address had imem_ready=1.
- FSM:
  - FETCH -> WAIT when imem_ready=0 and no redirect.
  - WAIT -> FETCH when imem_ready=1 or redirect.
  - fetch_wait = (state==WAIT).
- Wait counter:
  - wait_cnt increments by 1 on each edge with imem_ready=0 and no redirect, saturating at TIMEOUT.
  - It clears to 0 on imem_ready=1 or redirect.
  - imem_timeout sets on the edge where wait_cnt would reach TIMEOUT, and stays set until reset.
  - Fetching continues normally after timeout; the flag is report-only.
- A redirect during WAIT abandons the pending fetch: the new address is presented next cycle and the old imem_rdata is never captured.
- A hazard stall (pc_write=0, if_id_write=0) during WAIT holds PC and IF/ID. The wait counter still runs on imem_ready.

Test Plan:
1. Reset and first fetch:
   - Stimulus: rst_n=0 for 2 cycles, then release with ready=1 and rdata=0x8C08_0004.
   - Required: during reset pc=0, if_id_valid=0, if_id_instr=0. After the first edge, if_id_instr=0x8C08_0004, if_id_pc4=4, valid=1, pc=4.
2. Load-use stall:
   - Stimulus: at pc=8, pc_write=0 and if_id_write=0 for 1 cycle.
   - Required: pc stays 8 and IF/ID holds the lw at pc4=8. The next cycle loads rdata at 8 with pc4=0xC, and pc=0xC.
3. Memory wait:
   - Stimulus: ready=0 for 3 cycles at pc=0x10.
   - Required: pc=0x10 throughout, if_id_valid=0 each cycle, fetch_wait=1. With ready=1, rdata is captured with pc4=0x14 and fetch_wait=0.
4. Redirect priority:
   - Stimulus: branch_taken=1, branch_target=0x40, jump=1, jump_target=0x80, if_id_write=0, all in one cycle.
   - Required: pc=0x40, IF/ID bubble (valid=0).
5. Timeout:
   - Stimulus: TIMEOUT=4, ready=0 for 4 cycles.
   - Required: imem_timeout=1 after the 4th edge and stays 1 after ready returns. It clears only after an rst_n=0 edge.
6. Reset mid-WAIT:
   - Stimulus: ready=0 for 2 cycles, then rst_n=0.
   - Required: on the next edge pc=RESET_PC, FSM=FETCH, wait_cnt=0, fetch_wait=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory addressing, IF/ID
// pipeline register, branch/jump redirect, ready-handshake wait and timeout flag.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fetch_wait,
  output logic        imem_timeout
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_WAIT  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic              redirect;
  logic [31:0]       redirect_target;
  logic [31:0]       pc_plus4;
  logic              stalled_on_mem;

  assign redirect        = branch_taken | jump;
  assign redirect_target = branch_taken ? branch_target : jump_target;
  assign pc_plus4        = pc_q + 32'd4;
  assign stalled_on_mem  = ~imem_ready & ~redirect;

  // PC next-state
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_target;
    end else if (pc_write && imem_ready) begin
      pc_d = pc_plus4;
    end
  end

  // IF/ID next-state; a redirect squashes the wrong-path fetch even under a hazard hold
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (redirect || (if_id_write && (!imem_ready || !pc_write))) begin
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (if_id_write) begin
      instr_d = imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // Fetch FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (stalled_on_mem) state_d = S_WAIT;
      S_WAIT:  if (!stalled_on_mem) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Wait counter and sticky timeout; the flag is report-only and never blocks fetch
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (!stalled_on_mem) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (cnt_q >= CNT_LAST) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pc4_q     <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_valid  = valid_q;
  assign fetch_wait   = (state_q == S_WAIT);
  assign imem_timeout = timeout_q;

endmodule
